// File: rtl/key_entry_conditioner.sv
// rtl/key_entry_conditioner.sv - button/switch synchroniser, debouncer and digit strobe generator (optional ENTRY_TIMEOUT_EN)
module key_entry_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic [3:0] sw,
  input  logic       clr,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       digit_bad,
  output logic [2:0] entry_count,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, DOWN, RELEASE_DB} state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       COUNT_MAX = 3'd6;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_s1_q, key_s2_q;
  logic [3:0]       sw_s1_q, sw_s2_q;
  logic [3:0]       digit_q;
  logic             valid_q;
  logic [2:0]       count_q;
  logic             pressed;

  assign pressed = ~key_s2_q;

  // Two-flop synchronisers; the key resets to released so no phantom press follows reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      sw_s1_q  <= 4'd0;
      sw_s2_q  <= 4'd0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Debounce FSM; starting in RELEASE_DB means a button held through reset lands in DOWN without a strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASE_DB;
      cnt_q   <= '0;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed) begin
            state_q <= PRESS_DB;
            cnt_q   <= '0;
          end
        end
        PRESS_DB: begin
          if (!pressed) begin
            state_q <= IDLE;
          end else if (cnt_q == DB_LAST) begin
            state_q <= DOWN;
            digit_q <= sw_s2_q;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DOWN: begin
          if (!pressed) begin
            state_q <= RELEASE_DB;
            cnt_q   <= '0;
          end
        end
        RELEASE_DB: begin
          if (pressed) begin
            state_q <= DOWN;
          end else if (cnt_q == DB_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q;
  logic             timeout_q;

  // Entry counter plus inactivity timer that abandons a partial entry while the button sits idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 3'd0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (clr) begin
        count_q <= 3'd0;
        timer_q <= '0;
      end else if (valid_q) begin
        timer_q <= '0;
        if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
      end else if (count_q != 3'd0 && state_q == IDLE) begin
        if (timer_q == TMR_LAST) begin
          timeout_q <= 1'b1;
          count_q   <= 3'd0;
          timer_q   <= '0;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  assign timeout = timeout_q;
`else
  // Entry counter; clr has priority over a coincident strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 3'd0;
    end else if (clr) begin
      count_q <= 3'd0;
    end else if (valid_q && count_q != COUNT_MAX) begin
      count_q <= count_q + 1'b1;
    end
  end

  // No timer in this build; the expression is constant 0 for any legal TIMEOUT_CYCLES
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign digit_bad   = valid_q & (digit_q > 4'd9);
  assign entry_count = count_q;

endmodule

// File: doc/key_entry_conditioner.md
Name: key_entry_conditioner

Overview:
Input-conditioning stage that sits directly upstream of the combination-lock state machine. It synchronises the raw active-low push-button and the 4-bit digit switches, then debounces the button. For each clean press it emits exactly one single-cycle digit strobe carrying the sampled digit, and it also flags invalid digits and counts entries. The lock consumes digit_out/digit_valid in place of raw SW/KEY.

Parameters:
DEBOUNCE_CYCLES, 50000, cycles the synchronised button must stay stable to accept a press or a release (1 ms at 50 MHz); minimum 2.
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
TIMEOUT_CYCLES, 250000000, inactivity limit; used only with ENTRY_TIMEOUT_EN.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
key_n  input  1  raw push-button, 0 = pressed, asynchronous.
sw  input  4  raw digit switches, asynchronous.
clr  input  1  synchronous clear of entry_count (already clean, one cycle or longer).
digit_out  output  4  digit captured at accept; held until next accept.
digit_valid  output  1  one-cycle strobe per accepted press.
digit_bad  output  1  equals digit_valid AND digit_out > 9.
entry_count  output  3  accepted presses since reset/clr, saturates at 6.
timeout  output  1  one-cycle inactivity pulse (see Optional Feature).

Behaviour:
- Reset values: digit_out=0, digit_valid=0, digit_bad=0, entry_count=0, timeout=0, cnt=0.
- Synchronisers: two-flop synchronisers on key_n and sw. The key_n flops reset to 1 (released); the sw flops reset to 0. "pressed" is the second key_n flop == 0.
- FSM states: IDLE, PRESS_DB, DOWN, RELEASE_DB. The reset state is RELEASE_DB with cnt=0.
- IDLE: pressed -> PRESS_DB with cnt=0.
- PRESS_DB:
  - Released -> IDLE (glitch rejected, no strobe).
  - Pressed and cnt < DEBOUNCE_CYCLES-1 -> cnt+1.
  - Pressed and cnt == DEBOUNCE_CYCLES-1 -> DOWN; capture the synchronised sw into digit_out on that edge.
- DOWN:
  - digit_valid=1 only in the first cycle after entering from PRESS_DB.
  - Released -> RELEASE_DB with cnt=0.
- RELEASE_DB:
  - Pressed -> DOWN without a strobe (bounce on release).
  - Released and cnt == DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise cnt+1.
- Latency: if key_n is sampled low at edge N and stays low, PRESS_DB is entered at N+2, DOWN at N+2+DEBOUNCE_CYCLES, and digit_valid is high in the cycle after that edge.
- Reset while the button is held: the FSM starts in RELEASE_DB, goes to DOWN with no strobe, and a release plus a new press is required before the next strobe.
- Reset mid-debounce: all state is discarded immediately (asynchronous).
- sw changing during the press: only the value at the capture edge matters.
- entry_count: +1 on each digit_valid, holds at 6.
- clr and digit_valid in the same cycle: clr wins, entry_count=0; the strobe and digit still go out.
- digit_bad is combinational from the registered digit_valid/digit_out, so it is glitch-free and has the same timing as digit_valid.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined: a timer is cleared on every digit_valid, clr, or rst. The timer runs only while entry_count != 0 and the FSM is IDLE. When it reaches TIMEOUT_CYCLES-1, timeout pulses for one cycle, entry_count becomes 0, and the timer clears.
- Not defined: timeout is tied to 0, no timer logic exists, and entry_count changes only via strobe, clr, or rst.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
1. rst, sw=4, key_n low from edge 10 and held for 20 cycles -> exactly one digit_valid, in the cycle after edge 16; digit_out=4, digit_bad=0, entry_count=1.
2. key_n low for 2 cycles, then high (glitch) -> no digit_valid, FSM back in IDLE, entry_count unchanged.
3. Press accepted, then release that bounces 1/0/1/0/1 with each level held less than 4 cycles, then stable high -> only one strobe total; next clean press with sw=8 -> second strobe, digit_out=8, entry_count=2.
4. sw=4'b1100, clean press -> digit_valid=1 and digit_bad=1 in the same cycle, digit_out=12. Seven clean presses -> entry_count saturates at 6.
5. Button held through rst deassert -> no strobe until a release of at least 4 cycles plus a new press. Asserting clr in the same cycle as a digit_valid -> entry_count=0.
6. (ENTRY_TIMEOUT_EN) One press, then idle 20 cycles -> timeout high for 1 cycle and entry_count=0. Without the macro, timeout stays 0 and entry_count stays 1.
